// File: rtl/morse_letter_decoder_if.sv
// Interface bundling the keyed-line inputs and the decoded-letter outputs of
// the Morse letter decoder.
interface morse_letter_decoder_if;
    logic       tick;
    logic       key;
    logic [2:0] letter;
    logic [2:0] size;
    logic       valid;
    logic       error;
    logic       busy;

    modport master (
        output tick,
        output key,
        input  letter,
        input  size,
        input  valid,
        input  error,
        input  busy
    );

    modport slave (
        input  tick,
        input  key,
        output letter,
        output size,
        output valid,
        output error,
        output busy
    );
endinterface

// File: rtl/morse_letter_decoder.sv
// Receive-side Morse decoder for letters A-H: times marks and spaces on a ticked
// timebase, collects up to four dot/dash symbols and decodes the letter code.
module morse_letter_decoder #(
    parameter int DOT_MAX = 2,
    parameter int GAP_END = 3,
    parameter int CNT_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    morse_letter_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_END - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       pattern_r;
    logic [2:0]       nsym_r;
    logic             ovf_r;
    logic [2:0]       letter_r;
    logic [2:0]       size_r;
    logic             valid_r;
    logic             error_r;
    logic             busy_r;

    logic [CNT_W-1:0] cnt_inc_s;
    logic             sym_s;
    logic [3:0]       decode_s;
    logic             hit_s;
    logic [2:0]       code_s;

    // Pattern table: returns {match, letter code}; the symbol count is part of
    // the key because the pattern register keeps leading zeros.
    function automatic logic [3:0] decode_letter(input logic [2:0] n, input logic [3:0] p);
        logic [3:0] r;
        case ({n, p})
            7'b010_0001: r = 4'b1_000;
            7'b100_1000: r = 4'b1_001;
            7'b100_1010: r = 4'b1_010;
            7'b011_0100: r = 4'b1_011;
            7'b001_0000: r = 4'b1_100;
            7'b100_0010: r = 4'b1_101;
            7'b011_0110: r = 4'b1_110;
            7'b100_0000: r = 4'b1_111;
            default:     r = 4'b0_000;
        endcase
        return r;
    endfunction

    // Saturating tick counter increment, mark classification and letter lookup.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
        sym_s    = (cnt_r > DOT_LIM);
        decode_s = decode_letter(nsym_r, pattern_r);
        hit_s    = decode_s[3] & ~ovf_r;
        code_s   = decode_s[2:0];
    end

    // Decoder FSM with registered outputs; a key change overrides a coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            pattern_r <= 4'd0;
            nsym_r    <= 3'd0;
            ovf_r     <= 1'b0;
            letter_r  <= 3'd0;
            size_r    <= 3'd0;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.key) begin
                        state_r   <= MARK;
                        busy_r    <= 1'b1;
                        cnt_r     <= '0;
                        pattern_r <= 4'd0;
                        nsym_r    <= 3'd0;
                        ovf_r     <= 1'b0;
                    end
                end
                MARK: begin
                    if (bus.key) begin
                        if (bus.tick) begin
                            cnt_r <= cnt_inc_s;
                        end
                    end else begin
                        // A fifth symbol is not stored; it only poisons the letter.
                        if (nsym_r < 3'd4) begin
                            pattern_r <= {pattern_r[2:0], sym_s};
                            nsym_r    <= nsym_r + 3'd1;
                        end else begin
                            ovf_r <= 1'b1;
                        end
                        cnt_r   <= '0;
                        state_r <= SPACE;
                    end
                end
                SPACE: begin
                    if (bus.key) begin
                        state_r <= MARK;
                        cnt_r   <= '0;
                    end else if (bus.tick) begin
                        if (cnt_r == GAP_LAST) begin
                            state_r <= DONE;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                end
                DONE: begin
                    if (hit_s) begin
                        letter_r <= code_s;
                        size_r   <= nsym_r;
                        valid_r  <= 1'b1;
                    end else begin
                        error_r <= 1'b1;
                    end
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.letter = letter_r;
    assign bus.size   = size_r;
    assign bus.valid  = valid_r;
    assign bus.error  = error_r;
    assign bus.busy   = busy_r;

endmodule
